// File: rtl/lmsm_sequencer_if.sv
// Bus between the memory stage and the LM/SM sequencer: pipeline-side request
// fields, memory handshake, register-file steering and status.
interface lmsm_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              start;
    logic              is_lm;
    logic [7:0]        reg_list;
    logic [ADDR_W-1:0] base_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              stall;
    logic [2:0]        reg_sel;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              rf_we;
    logic [2:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              done;
    logic [3:0]        xfer_cnt;

    modport master (
        output start, is_lm, reg_list, base_addr, mem_ack, rd_data, mem_rdata,
        input  busy, stall, reg_sel, mem_req, mem_we, mem_addr, mem_wdata,
               rf_we, rf_waddr, rf_wdata, done, xfer_cnt
    );

    modport slave (
        input  start, is_lm, reg_list, base_addr, mem_ack, rd_data, mem_rdata,
        output busy, stall, reg_sel, mem_req, mem_we, mem_addr, mem_wdata,
               rf_we, rf_waddr, rf_wdata, done, xfer_cnt
    );
endinterface

// File: rtl/lmsm_sequencer.sv
// Load/store-multiple sequencer: walks the latched register list R0..R7 and
// issues one memory transfer per set bit at consecutive addresses.
module lmsm_sequencer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    lmsm_sequencer_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        pend_q, pend_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              lm_q, lm_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [2:0]        idx;

    // Lowest pending register goes first; scanning downward lets bit 0 win.
    always_comb begin
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pend_q[i]) idx = 3'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        addr_d  = addr_q;
        lm_d    = lm_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    pend_d  = bus.reg_list;
                    addr_d  = bus.base_addr;
                    lm_d    = bus.is_lm;
                    cnt_d   = 4'd0;
                    state_d = (bus.reg_list != 8'd0) ? ST_ACTIVE : ST_DONE;
                end
            end
            ST_ACTIVE: begin
                if (bus.mem_ack) begin
                    pend_d = pend_q & ~(8'd1 << idx);
                    addr_d = addr_q + ADDR_W'(1);
                    cnt_d  = cnt_q + 4'd1;
                    if (pend_d == 8'd0) state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Transfer controls are only live while ACTIVE so IDLE/DONE present a quiet bus.
    always_comb begin
        bus.busy      = (state_q != ST_IDLE);
        bus.stall     = (state_q != ST_IDLE);
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.rf_we     = 1'b0;
        bus.reg_sel   = 3'd0;
        bus.rf_waddr  = 3'd0;
        bus.mem_addr  = '0;
        bus.done      = (state_q == ST_DONE);
        bus.xfer_cnt  = cnt_q;
        bus.mem_wdata = DATA_W'(bus.rd_data);
        bus.rf_wdata  = DATA_W'(bus.mem_rdata);
        if (state_q == ST_ACTIVE) begin
            bus.mem_req  = 1'b1;
            bus.mem_we   = !lm_q;
            bus.rf_we    = lm_q & bus.mem_ack;
            bus.reg_sel  = idx;
            bus.rf_waddr = idx;
            bus.mem_addr = addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pend_q  <= 8'd0;
            addr_q  <= '0;
            lm_q    <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            lm_q    <= lm_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Bench for lmsm_sequencer: directed and random LM/SM sequences compared
// against a register-list/address model built from the transfer rules.
module tb_lmsm_sequencer;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    lmsm_sequencer_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    lmsm_sequencer #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.start     = 1'b0;
        bus.is_lm     = 1'b0;
        bus.reg_list  = 8'd0;
        bus.base_addr = 16'd0;
        bus.mem_ack   = 1'b0;
        bus.rd_data   = 16'd0;
        bus.mem_rdata = 16'd0;
    endtask

    // Reset held with start and ack high: reset must win and leave a quiet bus.
    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        bus.start    = 1'b1;
        bus.reg_list = 8'hFF;
        bus.mem_ack  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.stall, bus.mem_req, bus.mem_we, bus.rf_we, bus.done} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000000",
                     {bus.busy, bus.stall, bus.mem_req, bus.mem_we, bus.rf_we, bus.done});
        end
        checks++;
        if ({bus.reg_sel, bus.rf_waddr, bus.mem_addr, bus.xfer_cnt} !== 26'd0) begin
            failures++;
            $display("[TB] FAIL reset_fields: reg_sel=%0d rf_waddr=%0d addr=%h cnt=%0d expected all 0",
                     bus.reg_sel, bus.rf_waddr, bus.mem_addr, bus.xfer_cnt);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
    endtask

    // One full sequence from IDLE; expectations come from the ordered list of set bits.
    task automatic test_transfer_sequence(input string name, input logic lm,
                                          input logic [7:0] list, input logic [15:0] base,
                                          input logic [31:0] ackPat, input bit injectStart);
        int          regs[$];
        int          k;
        int          cyc;
        logic        ack;
        logic [15:0] expAddr;
        for (int i = 0; i < 8; i++) if (list[i]) regs.push_back(i);

        bus.start     = 1'b1;
        bus.is_lm     = lm;
        bus.reg_list  = list;
        bus.base_addr = base;
        bus.mem_ack   = 1'($urandom_range(0, 1));
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s idle_before_start: busy=%b expected 0", name, bus.busy);
        end
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.is_lm     = ~lm;
        bus.reg_list  = 8'($urandom);
        bus.base_addr = 16'($urandom);

        k   = 0;
        cyc = 0;
        while (k < regs.size() && cyc < 300) begin
            ack           = ackPat[cyc % 32];
            bus.mem_ack   = ack;
            bus.rd_data   = 16'($urandom);
            bus.mem_rdata = 16'($urandom);
            bus.start     = injectStart && (cyc == 1);
            if (injectStart) bus.reg_list = 8'h0F;
            expAddr = base + 16'(k);
            @(negedge clk);
            checks++;
            if ({bus.mem_req, bus.mem_we, bus.rf_we, bus.busy, bus.stall, bus.done}
                !== {1'b1, !lm, lm && ack, 1'b1, 1'b1, 1'b0}) begin
                failures++;
                $display("[TB] FAIL %s active_ctrl c%0d: req/we/rfwe/busy/stall/done=%b expected %b",
                         name, cyc + 1,
                         {bus.mem_req, bus.mem_we, bus.rf_we, bus.busy, bus.stall, bus.done},
                         {1'b1, !lm, lm && ack, 1'b1, 1'b1, 1'b0});
            end
            checks++;
            if (bus.reg_sel !== 3'(regs[k]) || bus.rf_waddr !== 3'(regs[k])) begin
                failures++;
                $display("[TB] FAIL %s reg_sel c%0d: reg_sel=%0d rf_waddr=%0d expected %0d",
                         name, cyc + 1, bus.reg_sel, bus.rf_waddr, regs[k]);
            end
            checks++;
            if (bus.mem_addr !== expAddr) begin
                failures++;
                $display("[TB] FAIL %s mem_addr c%0d: got %h expected %h",
                         name, cyc + 1, bus.mem_addr, expAddr);
            end
            checks++;
            if (bus.xfer_cnt !== 4'(k)) begin
                failures++;
                $display("[TB] FAIL %s xfer_cnt c%0d: got %0d expected %0d",
                         name, cyc + 1, bus.xfer_cnt, k);
            end
            checks++;
            if (bus.mem_wdata !== bus.rd_data || bus.rf_wdata !== bus.mem_rdata) begin
                failures++;
                $display("[TB] FAIL %s data_pass c%0d: wdata=%h/%h rfwdata=%h/%h",
                         name, cyc + 1, bus.mem_wdata, bus.rd_data, bus.rf_wdata, bus.mem_rdata);
            end
            @(posedge clk);
            #1;
            if (ack) k++;
            cyc++;
        end
        if (k < regs.size()) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s timeout: transfers=%0d expected %0d", name, k, regs.size());
        end

        bus.mem_ack  = 1'b1;
        bus.start    = injectStart;
        bus.reg_list = injectStart ? 8'h0F : 8'($urandom);
        @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.busy, bus.stall, bus.done} !== 4'b0111) begin
            failures++;
            $display("[TB] FAIL %s done_cycle c%0d: req/busy/stall/done=%b expected 0111",
                     name, cyc + 1, {bus.mem_req, bus.busy, bus.stall, bus.done});
        end
        checks++;
        if (bus.reg_sel !== 3'd0 || bus.xfer_cnt !== 4'(regs.size())) begin
            failures++;
            $display("[TB] FAIL %s done_fields: reg_sel=%0d cnt=%0d expected 0 and %0d",
                     name, bus.reg_sel, bus.xfer_cnt, regs.size());
        end
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.stall, bus.mem_req, bus.mem_we, bus.rf_we, bus.done} !== 6'b0 ||
            bus.xfer_cnt !== 4'(regs.size())) begin
            failures++;
            $display("[TB] FAIL %s back_idle: ctrl=%b cnt=%0d expected 000000 and %0d", name,
                     {bus.busy, bus.stall, bus.mem_req, bus.mem_we, bus.rf_we, bus.done},
                     bus.xfer_cnt, regs.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Reset lands in cycle 2 of an SM sequence with ack and start also high.
    task automatic test_reset_mid_sequence();
        bus.start     = 1'b1;
        bus.is_lm     = 1'b0;
        bus.reg_list  = 8'hF0;
        bus.base_addr = 16'h2000;
        bus.mem_ack   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.reg_sel !== 3'd4 || bus.mem_addr !== 16'h2000) begin
            failures++;
            $display("[TB] FAIL rst_mid c1: reg_sel=%0d addr=%h expected 4 2000", bus.reg_sel, bus.mem_addr);
        end
        @(posedge clk);
        #1;
        reset     = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.reg_sel !== 3'd5 || bus.mem_addr !== 16'h2001) begin
            failures++;
            $display("[TB] FAIL rst_mid c2: reg_sel=%0d addr=%h expected 5 2001", bus.reg_sel, bus.mem_addr);
        end
        @(posedge clk);
        #1;
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.stall, bus.mem_req, bus.mem_we, bus.rf_we, bus.done} !== 6'b0 ||
            {bus.reg_sel, bus.rf_waddr, bus.mem_addr, bus.xfer_cnt} !== 26'd0) begin
            failures++;
            $display("[TB] FAIL rst_mid after: ctrl=%b sel=%0d addr=%h cnt=%0d expected all 0",
                     {bus.busy, bus.stall, bus.mem_req, bus.mem_we, bus.rf_we, bus.done},
                     bus.reg_sel, bus.mem_addr, bus.xfer_cnt);
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rst_mid quiet%0d: done=%b busy=%b expected 0 0", c, bus.done, bus.busy);
            end
        end
        @(posedge clk);
        #1;
        test_transfer_sequence("after_reset", 1'b0, 8'h01, 16'h0040, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0]  list;
        logic [31:0] pat;
        for (int n = 0; n < 20; n++) begin
            list = 8'($urandom);
            pat  = $urandom | $urandom;
            test_transfer_sequence("random", 1'($urandom), list, 16'($urandom), pat,
                                   1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_transfer_sequence("sm_8d", 1'b0, 8'h8D, 16'h0100, 32'hFFFF_FFFF, 1'b0);
        test_transfer_sequence("lm_ff_wrap", 1'b1, 8'hFF, 16'hFFFE, 32'hFFFF_FFFF, 1'b0);
        test_transfer_sequence("lm_ack_gaps", 1'b1, 8'h12, 16'h0300, 32'hFFFF_FFF2, 1'b0);
        test_transfer_sequence("empty_list", 1'b0, 8'h00, 16'h0500, 32'hFFFF_FFFF, 1'b0);
        test_reset_mid_sequence();
        test_transfer_sequence("start_ignored", 1'b0, 8'hA4, 16'h0700, 32'hFFFF_FFFF, 1'b1);
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lmsm_sequencer.md
# lmsm_sequencer

Multi-cycle sequencer for the IITB-RISC load-multiple (LM) and store-multiple (SM) instructions. It walks an 8-bit register list from R0 to R7. For each set bit it drives the 3-bit select of the register-file read 8:1 mux (SM) or the register-file write address (LM), and issues one memory word transfer at consecutive addresses. The block sits beside the memory stage. It holds the pipeline stalled until the whole list has been transferred.

## Interface

Parameters:
- `ADDR_W`, default 16: memory address width.
- `DATA_W`, default 16: data word width; data passes through unchanged.

Ports, clock and reset first:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: begin a sequence; sampled only in IDLE.
- `is_lm`  in  1: 1 = LM (memory to registers), 0 = SM (registers to memory); latched on start.
- `reg_list`  in  8: bit i set means register Ri takes part; latched on start.
- `base_addr`  in  ADDR_W: address of the first transfer; latched on start.
- `mem_ack`  in  1: memory accepts or completes the current transfer this cycle.
- `rd_data`  in  DATA_W: 8:1 mux output for SM; forwarded to `mem_wdata`.
- `mem_rdata`  in  DATA_W: memory read data for LM; forwarded to `rf_wdata`.
- `busy`  out  1: high in ACTIVE and DONE.
- `stall`  out  1: equal to `busy`; freezes the upstream pipeline stages.
- `reg_sel`  out  3: select for the register-file read 8:1 mux.
- `mem_req`  out  1: transfer request.
- `mem_we`  out  1: memory write enable (SM).
- `mem_addr`  out  ADDR_W: current transfer address.
- `mem_wdata`  out  DATA_W: equal to `rd_data`.
- `rf_we`  out  1: register-file write enable (LM).
- `rf_waddr`  out  3: register-file write address; equal to `reg_sel`.
- `rf_wdata`  out  DATA_W: equal to `mem_rdata`.
- `done`  out  1: one-cycle pulse when the sequence finishes.
- `xfer_cnt`  out  4: number of transfers completed in the current or last sequence (0..8).

## Operation

Internal state:
- `state` ∈ {IDLE, ACTIVE, DONE}
- `pend[7:0]`: remaining register list
- `addr`: current address
- `lm`: latched `is_lm`
- `cnt`: transfer counter

The current index `idx` is the lowest set bit of `pend`, found by priority encode with bit 0 first. It is 0 when `pend` is 0.

IDLE:
- `busy`, `stall`, `mem_req`, `mem_we`, `rf_we` and `done` are 0.
- On `start`: `pend` ← `reg_list`, `addr` ← `base_addr`, `lm` ← `is_lm`, `cnt` ← 0.
- If `reg_list` is nonzero, go to ACTIVE; if it is zero, go to DONE.

ACTIVE:
- Outputs: `mem_req` = 1, `reg_sel` = `rf_waddr` = `idx`, `mem_addr` = `addr`, `mem_we` = !`lm`, `rf_we` = `lm` & `mem_ack` (combinational).
- On `mem_ack`:
  - clear `pend[idx]`
  - `addr` ← `addr` + 1, modulo 2^ADDR_W (wraps from 0xFFFF to 0x0000)
  - `cnt` ← `cnt` + 1
  - if `pend` becomes 0, go to DONE.
- Without `mem_ack`: hold all state and outputs. There is no timeout.

DONE:
- `done` = 1, `busy` = 1, `mem_req` = 0.
- Next cycle go to IDLE.

Other rules:
- `start` is ignored outside IDLE. Input changes after latching have no effect.
- `reg_sel` in IDLE and DONE is 0.
- `xfer_cnt` = `cnt`; it holds its value in IDLE until the next `start`.
- `reset` in any state, including mid-sequence: next cycle the block is in IDLE with `pend` = 0, `addr` = 0, `cnt` = 0 and every output 0. No partial transfer is resumed. `reset` wins over a simultaneous `start` or `mem_ack`.

## Timing

- Start at edge 0 puts the block in ACTIVE during cycle 1, with the first request visible in cycle 1.
- With N set bits and `mem_ack` high every cycle:
  - transfers occur in cycles 1..N
  - `done` is high in cycle N+1
  - the block is back in IDLE in cycle N+2.
  - Total stall: N+1 cycles.
- Each cycle `mem_ack` is low adds exactly one stall cycle.
- Empty list: `done` in cycle 1, IDLE in cycle 2, no `mem_req`.
- `start` sampled in the same cycle as `done` (DONE state) is ignored. A new `start` is accepted only from cycle N+2.
- All state is registered. `rf_we`, `mem_wdata` and `rf_wdata` are combinational from registered state plus inputs.

## Test plan

1. SM, `reg_list` = 0x8D, `base_addr` = 0x0100, `mem_ack` held high → `reg_sel` = 0, 2, 3, 7 at addresses 0x0100–0x0103, `mem_we` = 1 on each, `rf_we` = 0, `done` in cycle 5, `xfer_cnt` = 4.
2. LM, `reg_list` = 0xFF, `base_addr` = 0xFFFE, `mem_ack` high → `rf_waddr` = 0..7 at addresses 0xFFFE, 0xFFFF, 0x0000 … 0x0005, `rf_we` = 1 on each, `done` in cycle 9, `xfer_cnt` = 8.
3. LM, `reg_list` = 0x12, `mem_ack` pattern 0,1,0,0,1 → outputs hold while `mem_ack` = 0, R1 is written in cycle 2 and R4 in cycle 5, `done` in cycle 6.
4. `reg_list` = 0x00 → `mem_req` never asserted, `done` in cycle 1, `xfer_cnt` = 0.
5. `reset` asserted in cycle 2 of an SM with `reg_list` = 0xF0 → IDLE next cycle, all outputs 0, `done` never pulses. A following `start` with `reg_list` = 0x01 runs normally.
6. `start` pulsed with `reg_list` = 0x0F while ACTIVE and again in the DONE cycle → both ignored. The original sequence completes unchanged and `busy` drops after one DONE cycle.
